controle_reservatorio: RTL
==========================

CONTROLE_RESERVATORIO -- requirements
Module: controle_reservatorio

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable cycles required to accept a sensor change.
REQ-002 Parameter FILL_TIMEOUT, default 1000: maximum cycles allowed in ENCHENDO before a fill error.
REQ-003 Parameter CLEAN_PERIOD, default 8: completed fills before a cleaning request.
REQ-004 Clock  input  1  system clock; all logic on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Sensor_Baixo  input  1  raw low-level probe; 1 = wet; asynchronous to Clock.
REQ-007 Sensor_Medio  input  1  raw mid-level probe; 1 = wet; asynchronous.
REQ-008 Sensor_Alto  input  1  raw high-level probe; 1 = wet; asynchronous.
REQ-009 Irrigando  input  1  downstream irrigation FSM is drawing water (sprinkler or drip active).
REQ-010 Fim_Limpeza  input  1  cleaning cycle finished, from downstream.
REQ-011 Rearme  input  1  operator re-arm after an error.
REQ-012 Ve  output  1  inlet valve open; feeds downstream Ve.
REQ-013 H  output  1  tank full; feeds downstream H.
REQ-014 L  output  1  cleaning request; feeds downstream L.
REQ-015 E  output  1  error; feeds downstream E.
REQ-016 Nivel  output  2  filtered level: 0 empty, 1 low, 2 mid, 3 high.

Function
REQ-017 Each raw sensor SHALL pass through a 2-flop synchronizer, then a per-sensor debounce counter.
REQ-018 A filtered sensor SHALL toggle only after the synchronized value differs from it for DEB_CYCLES consecutive cycles; any agreeing cycle clears that counter.
REQ-019 Sensor-to-filtered latency SHALL be exactly 2 + DEB_CYCLES cycles.
REQ-020 Nivel SHALL be the count of wet filtered sensors when the combination is valid, and SHALL hold its last valid value otherwise.
REQ-021 A combination is invalid when a higher sensor is wet while any lower sensor is dry (e.g. Alto=1, Medio=0).
REQ-022 FSM states SHALL be ENCHENDO, CHEIO, LIMPEZA, ERRO.
REQ-023 Moore outputs SHALL be decoded from the state register with no extra cycle: ENCHENDO Ve=1; CHEIO H=1; LIMPEZA L=1; ERRO E=1; all others 0.
REQ-024 In any non-ERRO state, an invalid combination SHALL move the FSM to ERRO on the next edge; this takes highest priority.
REQ-025 ENCHENDO: filtered Alto=1 SHALL move to CHEIO and increment fill_count (saturating at CLEAN_PERIOD).
REQ-026 ENCHENDO: otherwise, when timeout_count reaches FILL_TIMEOUT-1, the FSM SHALL move to ERRO.
REQ-027 If Alto=1 and the timeout occur in the same cycle, CHEIO SHALL win.
REQ-028 timeout_count SHALL be cleared on every entry to ENCHENDO, increment each cycle in ENCHENDO, and be sized clog2(FILL_TIMEOUT)+1 bits.
REQ-029 CHEIO: leaving SHALL occur when Nivel==0, or when Nivel==1 and Irrigando==0; Nivel==1 with Irrigando==1 SHALL stay in CHEIO.
REQ-030 Leaving CHEIO SHALL go to LIMPEZA if fill_count==CLEAN_PERIOD, else to ENCHENDO.
REQ-031 LIMPEZA: Fim_Limpeza=1 with Nivel==0 SHALL move to ENCHENDO and clear fill_count; Fim_Limpeza with Nivel>0 SHALL be ignored.
REQ-032 ERRO: Rearme=1 with a valid combination SHALL move to ENCHENDO; Rearme with an invalid combination SHALL be ignored.
REQ-033 fill_count SHALL NOT change in ERRO.

Reset
REQ-034 Reset SHALL force the following immediately, without waiting for Clock: state ENCHENDO; Ve=1; H=0; L=0; E=0; Nivel=0; all synchronizers, filtered sensors, debounce counters, timeout_count and fill_count to 0.
REQ-035 Reset asserted mid-operation, in any state, SHALL abort that state with no residual count.

Verification (DEB_CYCLES=4, FILL_TIMEOUT=50, CLEAN_PERIOD=2)
REQ-036 Release reset, then raise Baixo at t0, Medio at t0+10, Alto at t0+20, all held -> Nivel steps 1,2,3; H=1 and Ve=0 at t0+26 (the Alto edge, 6 cycles after Alto rises).
REQ-037 In ENCHENDO, Alto pulsed high for 3 cycles, then low -> Nivel and H unchanged; Ve stays 1.
REQ-038 No sensors wet after reset -> E=1 and Ve=0 exactly 50 cycles after reset release; Rearme=1 -> Ve=1 next cycle.
REQ-039 Alto=1, Baixo=0, Medio=0 held -> E=1 six cycles after Alto rises; Rearme held -> remains ERRO; drop Alto and pulse Rearme -> ENCHENDO.
REQ-040 Complete two fills, then drain to Nivel 0 with Irrigando=0 -> L=1; Fim_Limpeza=1 -> ENCHENDO with fill_count 0; third full tank -> H=1.
REQ-041 Assert Reset while in CHEIO with Nivel=3 -> Ve=1, H=0, Nivel=0 immediately; H re-asserts 6 cycles after release (sensors still wet).

Source files
------------

// File: rtl/controle_reservatorio.sv
// Tank level controller: synchronizes and debounces three level probes, derives a
// filtered level and runs the fill / full / cleaning / error state machine.
module controle_reservatorio #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned FILL_TIMEOUT = 1000,
  parameter int unsigned CLEAN_PERIOD = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Sensor_Baixo,
  input  logic       Sensor_Medio,
  input  logic       Sensor_Alto,
  input  logic       Irrigando,
  input  logic       Fim_Limpeza,
  input  logic       Rearme,
  output logic       Ve,
  output logic       H,
  output logic       L,
  output logic       E,
  output logic [1:0] Nivel
);

  localparam int unsigned DebW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int unsigned ToW   = $clog2(FILL_TIMEOUT) + 1;
  localparam int unsigned FillW = $clog2(CLEAN_PERIOD + 1);

  typedef enum logic [1:0] {Enchendo, Cheio, Limpeza, Erro} state_e;

  state_e                state_q, state_d;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            filt_q, filt_d;
  logic [2:0][DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [ToW-1:0]        timeout_count_q, timeout_count_d;
  logic [FillW-1:0]      fill_count_q, fill_count_d;
  logic [1:0]            nivel_q, nivel_d;
  logic [1:0]            wet_count;
  logic                  combo_ok;

  // Bit 0 = Baixo, bit 1 = Medio, bit 2 = Alto.
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == DebW'(DEB_CYCLES - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // The FSM looks at the filtered value being committed this edge, so a sensor change
  // and the state reaction it causes land on the same clock edge.
  always_comb begin
    combo_ok  = !(filt_d[2] && !filt_d[1]) && !(filt_d[1] && !filt_d[0]);
    wet_count = {1'b0, filt_d[0]} + {1'b0, filt_d[1]} + {1'b0, filt_d[2]};
    nivel_d   = combo_ok ? wet_count : nivel_q;
  end

  always_comb begin
    state_d      = state_q;
    fill_count_d = fill_count_q;
    if (state_q != Erro && !combo_ok) begin
      state_d = Erro;
    end else begin
      case (state_q)
        Enchendo: begin
          if (filt_d[2]) begin
            state_d = Cheio;
            if (fill_count_q != FillW'(CLEAN_PERIOD)) begin
              fill_count_d = fill_count_q + 1'b1;
            end
          end else if (timeout_count_q == ToW'(FILL_TIMEOUT - 1)) begin
            state_d = Erro;
          end
        end
        Cheio: begin
          if (nivel_d == 2'd0 || (nivel_d == 2'd1 && !Irrigando)) begin
            state_d = (fill_count_q == FillW'(CLEAN_PERIOD)) ? Limpeza : Enchendo;
          end
        end
        Limpeza: begin
          if (Fim_Limpeza && nivel_d == 2'd0) begin
            state_d      = Enchendo;
            fill_count_d = '0;
          end
        end
        Erro: begin
          if (Rearme && combo_ok) begin
            state_d = Enchendo;
          end
        end
        default: state_d = Enchendo;
      endcase
    end
    // Any stay outside ENCHENDO leaves the counter at zero for the next entry.
    timeout_count_d = (state_q == Enchendo && state_d == Enchendo) ?
                      timeout_count_q + 1'b1 : '0;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q         <= Enchendo;
      sync1_q         <= '0;
      sync2_q         <= '0;
      filt_q          <= '0;
      deb_cnt_q       <= '0;
      timeout_count_q <= '0;
      fill_count_q    <= '0;
      nivel_q         <= '0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= {Sensor_Alto, Sensor_Medio, Sensor_Baixo};
      sync2_q         <= sync1_q;
      filt_q          <= filt_d;
      deb_cnt_q       <= deb_cnt_d;
      timeout_count_q <= timeout_count_d;
      fill_count_q    <= fill_count_d;
      nivel_q         <= nivel_d;
    end
  end

  always_comb begin
    Ve    = (state_q == Enchendo);
    H     = (state_q == Cheio);
    L     = (state_q == Limpeza);
    E     = (state_q == Erro);
    Nivel = nivel_q;
  end

endmodule
